// File: rtl/seven_seg_pkg.sv
// Shared definitions for the two-digit seven-segment display path:
// segment/word widths, the idle display word and the ownership states.
package seven_seg_pkg;

  localparam int SEG_W  = 7;
  localparam int DISP_W = 2 * SEG_W;

  localparam logic [DISP_W-1:0] BLANK_DEFAULT = '0;

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

endpackage

// File: rtl/seven_seg_rr_pick.sv
// Combinational round-robin picker: scans ptr+1, ptr+2, ..., ptr (mod NREQ)
// and returns the first requester that is asserted and not excluded.
module seven_seg_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic [NREQ-1:0] excl,
  output logic [NREQ-1:0] win,
  output logic            valid
);

  logic [PW-1:0] idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    // Offset NREQ wraps back to ptr itself, giving the last-granted lowest priority.
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!valid && req[idx] && !excl[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_arbiter.sv
// Round-robin display-ownership scheduler with a minimum hold time per owner;
// drives the registered 14-bit word to the seven-segment multiplexer.
module seven_seg_arbiter
  import seven_seg_pkg::*;
#(
  parameter int                NREQ  = 4,
  parameter int                HOLD  = 1600000,
  parameter int                CBITS = 21,
  parameter logic [DISP_W-1:0] BLANK = BLANK_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DISP_W-1:0] data,
  output logic [NREQ-1:0]        gnt,
  output logic [DISP_W-1:0]      both7seg,
  output logic                   switched
);

  localparam int               PW      = $clog2(NREQ);
  localparam logic [CBITS-1:0] CNT_MAX = CBITS'(HOLD - 1);

  state_t            state_reg, state_next;
  logic [PW-1:0]     ptr_reg, ptr_next;
  logic [CBITS-1:0]  cnt_reg, cnt_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [DISP_W-1:0] seg_reg, seg_next;
  logic              sw_reg, sw_next;

  logic [NREQ-1:0]   pick_excl, pick_win;
  logic              pick_valid;
  logic              owner_req;
  logic              take_new;
  logic [DISP_W-1:0] slice [NREQ];

  function automatic logic [PW-1:0] enc(input logic [NREQ-1:0] oh);
    enc = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) enc = PW'(i);
    end
  endfunction

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign slice[gi] = data[gi*DISP_W +: DISP_W];
  end

  // While owning, the current owner never competes in its own handover search.
  assign pick_excl = (state_reg == OWN) ? gnt_reg : '0;
  assign owner_req = |(req & gnt_reg);

  seven_seg_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .excl  (pick_excl),
    .win   (pick_win),
    .valid (pick_valid)
  );

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    gnt_next   = gnt_reg;
    take_new   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pick_valid) take_new = 1'b1;
      end
      OWN: begin
        if (!owner_req) begin
          if (pick_valid) begin
            take_new = 1'b1;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
            cnt_next   = '0;
          end
        end else if (cnt_reg == CNT_MAX && pick_valid) begin
          take_new = 1'b1;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        cnt_next   = '0;
      end
    endcase

    if (take_new) begin
      state_next = OWN;
      gnt_next   = pick_win;
      cnt_next   = '0;
      ptr_next   = enc(pick_win);
    end

    // New owner's data travels with its grant bit, so handover has no blank gap.
    seg_next = (|gnt_next) ? slice[enc(gnt_next)] : BLANK;
    sw_next  = (gnt_next != gnt_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= PW'(NREQ - 1);
      cnt_reg   <= '0;
      gnt_reg   <= '0;
      seg_reg   <= BLANK;
      sw_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
      seg_reg   <= seg_next;
      sw_reg    <= sw_next;
    end
  end

  assign gnt      = gnt_reg;
  assign both7seg = seg_reg;
  assign switched = sw_reg;

endmodule
